// File: rtl/sync_word_fifo.sv
// Single-clock, non-showahead word FIFO with a registered read port.
// Empty/full flags and usedw are registered from the next-state count.
module sync_word_fifo #(
  parameter int LPM_WIDTH    = 36,
  parameter int LPM_NUMWORDS = 4,
  parameter int LPM_WIDTHU   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [LPM_WIDTH-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [LPM_WIDTH-1:0]  q,
  output logic                  rdempty,
  output logic                  wrfull,
  output logic [LPM_WIDTHU:0]   usedw
);

  localparam logic [LPM_WIDTHU-1:0] PTR_ONE  = 1;
  localparam logic [LPM_WIDTHU:0]   CNT_ONE  = 1;
  localparam logic [LPM_WIDTHU:0]   CNT_FULL = LPM_NUMWORDS[LPM_WIDTHU:0];

  logic [LPM_WIDTH-1:0]  mem_q [LPM_NUMWORDS];
  logic [LPM_WIDTH-1:0]  mem_d [LPM_NUMWORDS];
  logic [LPM_WIDTHU-1:0] wr_ptr_q, wr_ptr_d;
  logic [LPM_WIDTHU-1:0] rd_ptr_q, rd_ptr_d;
  logic [LPM_WIDTHU:0]   usedw_q, usedw_d;
  logic [LPM_WIDTH-1:0]  q_q, q_d;
  logic                  rdempty_q, rdempty_d;
  logic                  wrfull_q, wrfull_d;
  logic                  wr_ok, rd_ok;

  // Acceptance uses the pre-edge flags, so full+both reads only
  // and empty+both writes only.
  always_comb begin
    wr_ok    = wrreq & ~wrfull_q;
    rd_ok    = rdreq & ~rdempty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    q_d      = q_q;
    usedw_d  = usedw_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (rd_ok) begin
      q_d      = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   usedw_d = usedw_q + CNT_ONE;
      2'b01:   usedw_d = usedw_q - CNT_ONE;
      default: usedw_d = usedw_q;
    endcase
    rdempty_d = (usedw_d == '0);
    wrfull_d  = (usedw_d == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      q_q       <= '0;
      rdempty_q <= 1'b1;
      wrfull_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      q_q       <= q_d;
      rdempty_q <= rdempty_d;
      wrfull_q  <= wrfull_d;
    end
  end

  assign q       = q_q;
  assign rdempty = rdempty_q;
  assign wrfull  = wrfull_q;
  assign usedw   = usedw_q;

endmodule

// File: tb/tb_sync_word_fifo.sv
// Scoreboard bench for sync_word_fifo: a queue model predicts each
// edge; a negedge monitor checks flags, count and q.
module tb_sync_word_fifo;

  localparam int W  = 36;
  localparam int N  = 4;
  localparam int WU = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  data = '0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic [W-1:0]  q;
  logic          rdempty;
  logic          wrfull;
  logic [WU:0]   usedw;

  sync_word_fifo #(
    .LPM_WIDTH   (W),
    .LPM_NUMWORDS(N),
    .LPM_WIDTHU  (WU)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .data   (data),
    .wrreq  (wrreq),
    .rdreq  (rdreq),
    .q      (q),
    .rdempty(rdempty),
    .wrfull (wrfull),
    .usedw  (usedw)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mdl [$];
  logic [W-1:0] sb  [$];
  int           exp_used = 0;
  bit           rd_fire  = 1'b0;
  bit           clr_q    = 1'b0;
  bit           armed    = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model advances using pre-edge occupancy.
  task automatic step(input bit rst, input bit wr, input bit rd,
                      input logic [W-1:0] d);
    @(negedge clk);
    #1;
    reset_n = ~rst;
    wrreq   = wr;
    rdreq   = rd;
    data    = d;
    rd_fire = 1'b0;
    clr_q   = 1'b0;
    if (rst) begin
      mdl.delete();
      clr_q = 1'b1;
    end else begin
      bit wo, ro;
      wo = wr && (mdl.size() < N);
      ro = rd && (mdl.size() > 0);
      if (ro) begin
        sb.push_back(mdl.pop_front());
        rd_fire = 1'b1;
      end
      if (wo) mdl.push_back(d);
    end
    exp_used = mdl.size();
    armed    = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  // Monitor: checks the state produced by the edge just passed.
  initial begin : monitor
    logic [W-1:0] held;
    held = '0;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (clr_q) held = '0;
        if (rd_fire) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: no expected word at %0t", $time);
          end else begin
            held = sb.pop_front();
          end
        end
        chk("q", q, held);
        chk("usedw", W'(usedw), W'(exp_used));
        chk("rdempty", W'(rdempty), W'(exp_used == 0));
        chk("wrfull", W'(wrfull), W'(exp_used == N));
      end
    end
  end

  initial begin
    logic [63:0] r;
    // reset then idle, rdreq on empty
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    idle(1);
    step(0, 0, 1, '0);
    idle(1);
    // single-word latency
    step(0, 1, 0, 36'h1_2345_6789);
    step(0, 0, 1, '0);
    idle(1);
    // fill and overflow
    step(0, 1, 0, 36'hA_AAAA_0001);
    step(0, 1, 0, 36'hB_BBBB_0002);
    step(0, 1, 0, 36'hC_CCCC_0003);
    step(0, 1, 0, 36'hD_DDDD_0004);
    step(0, 1, 0, 36'hE_EEEE_0005);
    // full with both asserted: read wins, write dropped
    step(0, 1, 1, 36'hF_0000_0006);
    for (int i = 0; i < 4; i++) step(0, 0, 1, '0);
    idle(1);
    // empty with both asserted: write only
    step(0, 1, 1, 36'h0_0000_0077);
    step(0, 0, 1, '0);
    idle(1);
    // wrap-around ordering, count held between 1 and 3
    step(0, 1, 0, 36'h01);
    step(0, 1, 0, 36'h02);
    for (int k = 3; k <= 10; k++) step(0, 1, 1, W'(k));
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    idle(1);
    // two queued, simultaneous ops keep count
    step(0, 1, 0, 36'h3_0000_0011);
    step(0, 1, 0, 36'h3_0000_0022);
    step(0, 1, 1, 36'h3_0000_0033);
    // mid-operation reset with wrreq
    step(0, 1, 0, 36'h3_0000_0044);
    step(1, 1, 0, 36'h5_5555_5555);
    step(0, 1, 0, 36'h6_0000_0066);
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    idle(1);
    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      r = {$urandom(), $urandom()};
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, r[W-1:0]);
    end
    idle(2);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
